control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit that sits directly upstream of `datapath` and replaces hand-sequenced bench stimulus. On every clock it decodes the current T-state and the latched instruction (`IR`) and drives the datapath's register-enable, bus-select, memory and ALU strobes. It covers three sequences: the fetch sequence, the register-register ALU ops (add, sub, and, or), `addi`, `nop` and `halt`.

## Interface
- Parameters:
- `IW`, 32, instruction width; field positions below assume 32.
- Ports (one clock, reset synchronous active-high):
- `Clock`  in  1  system clock, all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high; clears state and counters.
- `Stop`  in  1  request halt after the current instruction completes.
- `IR`  in  32  instruction register contents from `datapath`.
- `Rin`  out  16  one-hot general register load enables (bit n = Rn in).
- `Rout`  out  16  one-hot general register bus drives (bit n = Rn out).
- `PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, ZLOout, Cout`  out  1 each  datapath strobes; `Cout` drives sign-extended `IR[18:0]` onto the bus.
- `alu_op`  out  4  0000 none/increment, 0001 add, 0010 sub, 0011 and, 0100 or.
- `Run`  out  1  high while sequencing, low in RESET_ST and HALT.
- `illegal_op`  out  1  sticky; set on an undecodable opcode.
- `instr_count`  out  16  count of completed instructions.

## Operation
- IR fields: opcode `IR[31:27]`, Ra `IR[26:23]`, Rb `IR[22:19]`, Rc `IR[18:15]`, C `IR[18:0]`.
- Opcodes: 00011 add, 00100 sub, 00101 and, 00110 or, 01100 addi, 11010 nop, 11011 halt. Every other opcode is illegal.
- States: RESET_ST, T0, T1, T2, T3, T4, T5, HALT. Outputs are Moore, decoded combinationally from the state and `IR`. Every strobe not listed for a state is 0.
- T0: `PCout`, `MARin`, `IncPC`, `Zin`.
- T1: `ZLOout`, `PCin`, `Read`, `MDRin`. Memory returns data in the same cycle.
- T2: `MDRout`, `IRin`.
- T3: `Rout[Rb]`, `Yin`.
- T4, ALU op: `Rout[Rc]`, `Zin`, `alu_op` per opcode.
- T4, addi: `Cout`, `Zin`, `alu_op`=0001.
- T5: `ZLOout`, `Rin[Ra]`.
- Transitions:
  - RESET_ST → T0.
  - T0 → T1 → T2 → T3 (decode uses `IR` as loaded at the end of T2).
  - At T3 with nop: all strobes 0; go to T0 (or HALT if a stop is pending).
  - At T3 with halt: go to HALT.
  - At T3 with illegal opcode: set `illegal_op`, go to HALT.
  - Otherwise T3 → T4 → T5 → T0.
- Stop: sampled every cycle into a pending flag. The pending flag is acted on only at instruction end (T5 exit, or nop T3 exit), which goes to HALT instead of T0. The pending flag clears on entering HALT.
- `instr_count` increments by 1 on leaving T5, or on leaving T3 for nop or halt. It wraps 0xFFFF → 0x0000. It does not increment for illegal opcodes.
- HALT is terminal: all strobes 0 and `Run`=0 until `Reset`.

## Timing
- Reset at a rising edge with `Reset`=1:
  - Next state is RESET_ST.
  - `illegal_op`=0, `instr_count`=0, stop-pending=0.
  - All strobes 0, `alu_op`=0000, `Run`=0.
- Reset overrides any state, including mid-instruction and HALT. No partial strobe is issued in the following cycle.
- Each T-state lasts exactly one clock. The first T0 follows one cycle after reset is released.
- Instruction latency:
  - ALU op and addi: 6 cycles (T0–T5).
  - nop: 4 cycles (T0–T3).
  - halt: 4 cycles, to HALT.
- `Rin` and `Rout` are always either one-hot or zero. They are never both nonzero in the same cycle.
- `Stop` asserted in T5 of instruction N causes HALT after N. `Stop` asserted in T0 of instruction N+1 lets N+1 complete before HALT.

## Test plan
- Reset then `IR`=0x18918000 (add R1,R2,R3):
  - T0–T5 strobes exactly as listed.
  - T3 `Rout`=0x0004. T4 `Rout`=0x0008 with `alu_op`=0001. T5 `Rin`=0x0002.
  - `instr_count` is 1 after T5.
- `IR`=0x222B0000 (sub R4,R5,R6):
  - T3 `Rout`=0x0020. T4 `Rout`=0x0040 with `alu_op`=0010. T5 `Rin`=0x0010.
- `IR`=0xD0000000 (nop) twice:
  - Each instruction is 4 cycles with no T4/T5 strobes.
  - `instr_count`=2 after the eighth cycle.
- `IR`=0xD8000000 (halt):
  - HALT entered after T3, `Run`=0, `instr_count`=1.
  - Holding 10 cycles shows no change. `Reset` returns to RESET_ST then T0.
- `IR`=0xF8000000 (illegal):
  - `illegal_op`=1 and HALT after T3, `instr_count` unchanged.
  - Separately, assert `Reset` during T4 of an add: next cycle is RESET_ST with all outputs 0.
- `Stop` pulsed for one cycle during T2 of an add:
  - The add completes through T5, then HALT.
  - No T0 strobe follows.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired control unit for the datapath. Steps through the fetch T-states
// and, from the latched instruction, the execute T-states for register ALU
// ops (add/sub/and/or), addi, nop and halt. Strobes are Moore outputs decoded
// from the current state and IR.
//
// State table:
//   RESET_ST | idle after reset, all strobes low, Run low
//   T0       | PC -> MAR, start PC increment into Z
//   T1       | Z -> PC, memory read into MDR
//   T2       | MDR -> IR
//   T3       | decode; Rb -> Y for ALU/addi, nop/halt/illegal finish here
//   T4       | Rc (or C) through ALU into Z
//   T5       | Z -> Ra, instruction complete
//   HALT     | terminal until Reset, all strobes low, Run low
//
// Ports:
//   Clock, Reset (sync, active-high), Stop (halt request)
//   IR          instruction register contents
//   Rin, Rout   one-hot general register load / bus-drive enables
//   PCout .. Cout  single-bit datapath strobes
//   alu_op      0 none/inc, 1 add, 2 sub, 3 and, 4 or
//   Run         high while sequencing
//   illegal_op  sticky undecodable-opcode flag
//   instr_count completed instruction count (wraps)
module control_sequencer #(
  parameter int IW = 32
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Stop,
  input  logic [IW-1:0] IR,
  output logic [15:0]   Rin,
  output logic [15:0]   Rout,
  output logic          PCout,
  output logic          PCin,
  output logic          IncPC,
  output logic          MARin,
  output logic          Read,
  output logic          MDRin,
  output logic          MDRout,
  output logic          IRin,
  output logic          Yin,
  output logic          Zin,
  output logic          ZLOout,
  output logic          Cout,
  output logic [3:0]    alu_op,
  output logic          Run,
  output logic          illegal_op,
  output logic [15:0]   instr_count
);

  typedef enum logic [2:0] {
    RESET_ST, T0, T1, T2, T3, T4, T5, HALT
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state;
  logic       stop_pend;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_addi, is_nop, is_halt;
  logic [3:0] alu_code;
  logic       stop_now;

  // The C field is routed to the bus by the datapath, not used here.
  logic       unused_c;
  assign unused_c = ^IR[14:0];

  assign opcode = IR[31:27];
  assign ra     = IR[26:23];
  assign rb     = IR[22:19];
  assign rc     = IR[18:15];

  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_addi = (opcode == OP_ADDI);
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);

  // A Stop arriving in the final cycle of an instruction still counts.
  assign stop_now = stop_pend | Stop;

  always_comb begin
    alu_code = 4'b0000;
    case (opcode)
      OP_ADD:  alu_code = 4'b0001;
      OP_SUB:  alu_code = 4'b0010;
      OP_AND:  alu_code = 4'b0011;
      OP_OR:   alu_code = 4'b0100;
      OP_ADDI: alu_code = 4'b0001;
      default: alu_code = 4'b0000;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= RESET_ST;
      stop_pend   <= 1'b0;
      illegal_op  <= 1'b0;
      instr_count <= 16'h0000;
    end else begin
      stop_pend <= stop_pend | Stop;
      case (state)
        RESET_ST: state <= T0;
        T0:       state <= T1;
        T1:       state <= T2;
        T2:       state <= T3;
        T3: begin
          if (is_nop) begin
            instr_count <= instr_count + 16'h0001;
            if (stop_now) begin
              state     <= HALT;
              stop_pend <= 1'b0;
            end else begin
              state <= T0;
            end
          end else if (is_halt) begin
            instr_count <= instr_count + 16'h0001;
            state       <= HALT;
            stop_pend   <= 1'b0;
          end else if (is_alu || is_addi) begin
            state <= T4;
          end else begin
            illegal_op <= 1'b1;
            state      <= HALT;
            stop_pend  <= 1'b0;
          end
        end
        T4:       state <= T5;
        T5: begin
          instr_count <= instr_count + 16'h0001;
          if (stop_now) begin
            state     <= HALT;
            stop_pend <= 1'b0;
          end else begin
            state <= T0;
          end
        end
        HALT: begin
          state     <= HALT;
          stop_pend <= 1'b0;
        end
        default:  state <= RESET_ST;
      endcase
    end
  end

  always_comb begin
    Rin    = 16'h0000;
    Rout   = 16'h0000;
    PCout  = 1'b0;
    PCin   = 1'b0;
    IncPC  = 1'b0;
    MARin  = 1'b0;
    Read   = 1'b0;
    MDRin  = 1'b0;
    MDRout = 1'b0;
    IRin   = 1'b0;
    Yin    = 1'b0;
    Zin    = 1'b0;
    ZLOout = 1'b0;
    Cout   = 1'b0;
    alu_op = 4'b0000;
    Run    = 1'b0;
    case (state)
      T0: begin
        Run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Run    = 1'b1;
        ZLOout = 1'b1;
        PCin   = 1'b1;
        Read   = 1'b1;
        MDRin  = 1'b1;
      end
      T2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        Run = 1'b1;
        // nop, halt and illegal opcodes finish here with no bus activity.
        if (is_alu || is_addi) begin
          Rout = 16'h0001 << rb;
          Yin  = 1'b1;
        end
      end
      T4: begin
        Run    = 1'b1;
        Zin    = 1'b1;
        alu_op = alu_code;
        if (is_addi) Cout = 1'b1;
        else         Rout = 16'h0001 << rc;
      end
      T5: begin
        Run    = 1'b1;
        ZLOout = 1'b1;
        Rin    = 16'h0001 << ra;
      end
      default: begin
        Run = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        Clock;
  logic        Reset;
  logic        Stop;
  logic [31:0] IR;
  logic [15:0] Rin, Rout;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, ZLOout, Cout;
  logic [3:0]  alu_op;
  logic        Run, illegal_op;
  logic [15:0] instr_count;

  int vectors = 0;
  int errors  = 0;

  control_sequencer #(.IW(32)) dut (
    .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR),
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLOout(ZLOout), .Cout(Cout),
    .alu_op(alu_op), .Run(Run), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Strobe bits: PCout PCin IncPC MARin Read MDRin MDRout IRin Yin Zin ZLOout Cout
  localparam logic [11:0] S_T0   = 12'hB04;
  localparam logic [11:0] S_T1   = 12'h4C2;
  localparam logic [11:0] S_T2   = 12'h030;
  localparam logic [11:0] S_T3   = 12'h008;
  localparam logic [11:0] S_T4   = 12'h004;
  localparam logic [11:0] S_T4I  = 12'h005;
  localparam logic [11:0] S_T5   = 12'h002;

  logic [48:0] obs;
  assign obs = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                Yin, Zin, ZLOout, Cout, Rin, Rout, alu_op, Run};

  function automatic logic [48:0] vec(input logic [11:0] s, input logic [15:0] ri,
                                      input logic [15:0] ro, input logic [3:0] a,
                                      input logic r);
    return {s, ri, ro, a, r};
  endfunction

  localparam logic [48:0] V_IDLE = 49'h0;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Stop  = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    IR = 32'h18918000;
    do_reset();
    vectors++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", obs, V_IDLE);
    end
    vectors++;
    if (instr_count !== 16'h0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got cnt=%h ill=%b exp cnt=0000 ill=0", instr_count, illegal_op);
    end
    step();
    vectors++;
    if (obs !== vec(S_T0, 16'h0, 16'h0, 4'h0, 1'b1)) begin
      errors++;
      $display("FAIL reset_first_t0 got %h exp %h", obs, vec(S_T0, 16'h0, 16'h0, 4'h0, 1'b1));
    end
  endtask

  task automatic test_add();
    logic [48:0] exp [6];
    IR = 32'h18918000;
    do_reset();
    exp[0] = vec(S_T0, 16'h0, 16'h0, 4'h0, 1'b1);
    exp[1] = vec(S_T1, 16'h0, 16'h0, 4'h0, 1'b1);
    exp[2] = vec(S_T2, 16'h0, 16'h0, 4'h0, 1'b1);
    exp[3] = vec(S_T3, 16'h0, 16'h0004, 4'h0, 1'b1);
    exp[4] = vec(S_T4, 16'h0, 16'h0008, 4'h1, 1'b1);
    exp[5] = vec(S_T5, 16'h0002, 16'h0, 4'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL add_t%0d got %h exp %h", i, obs, exp[i]);
      end
    end
    vectors++;
    if (instr_count !== 16'h0000) begin
      errors++;
      $display("FAIL add_count_in_t5 got %h exp 0000", instr_count);
    end
    step();
    vectors++;
    if (instr_count !== 16'h0001 || obs !== exp[0]) begin
      errors++;
      $display("FAIL add_after_t5 got cnt=%h obs=%h exp cnt=0001 obs=%h", instr_count, obs, exp[0]);
    end
  endtask

  task automatic test_sub();
    logic [48:0] exp [3];
    IR = 32'h222B0000;
    do_reset();
    exp[0] = vec(S_T3, 16'h0, 16'h0020, 4'h0, 1'b1);
    exp[1] = vec(S_T4, 16'h0, 16'h0040, 4'h2, 1'b1);
    exp[2] = vec(S_T5, 16'h0010, 16'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL sub_t%0d got %h exp %h", i + 3, obs, exp[i]);
      end
    end
  endtask

  task automatic test_logic_addi();
    IR = 32'h28000000;  // and R0,R0,R0
    do_reset();
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (obs !== vec(S_T4, 16'h0, 16'h0001, 4'h3, 1'b1)) begin
      errors++;
      $display("FAIL and_t4 got %h exp %h", obs, vec(S_T4, 16'h0, 16'h0001, 4'h3, 1'b1));
    end
    IR = 32'h30000000;  // or R0,R0,R0
    do_reset();
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (obs !== vec(S_T4, 16'h0, 16'h0001, 4'h4, 1'b1)) begin
      errors++;
      $display("FAIL or_t4 got %h exp %h", obs, vec(S_T4, 16'h0, 16'h0001, 4'h4, 1'b1));
    end
    IR = 32'h60901234;  // addi R1,R2,0x1234
    do_reset();
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (obs !== vec(S_T3, 16'h0, 16'h0004, 4'h0, 1'b1)) begin
      errors++;
      $display("FAIL addi_t3 got %h exp %h", obs, vec(S_T3, 16'h0, 16'h0004, 4'h0, 1'b1));
    end
    step();
    vectors++;
    if (obs !== vec(S_T4I, 16'h0, 16'h0, 4'h1, 1'b1)) begin
      errors++;
      $display("FAIL addi_t4 got %h exp %h", obs, vec(S_T4I, 16'h0, 16'h0, 4'h1, 1'b1));
    end
    step();
    vectors++;
    if (obs !== vec(S_T5, 16'h0002, 16'h0, 4'h0, 1'b1)) begin
      errors++;
      $display("FAIL addi_t5 got %h exp %h", obs, vec(S_T5, 16'h0002, 16'h0, 4'h0, 1'b1));
    end
  endtask

  task automatic test_nop();
    logic [48:0] exp [4];
    IR = 32'hD0000000;
    do_reset();
    exp[0] = vec(S_T0, 16'h0, 16'h0, 4'h0, 1'b1);
    exp[1] = vec(S_T1, 16'h0, 16'h0, 4'h0, 1'b1);
    exp[2] = vec(S_T2, 16'h0, 16'h0, 4'h0, 1'b1);
    exp[3] = vec(12'h000, 16'h0, 16'h0, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (obs !== exp[i % 4]) begin
        errors++;
        $display("FAIL nop_cycle%0d got %h exp %h", i, obs, exp[i % 4]);
      end
    end
    step();
    vectors++;
    if (instr_count !== 16'h0002 || obs !== exp[0]) begin
      errors++;
      $display("FAIL nop_count got cnt=%h obs=%h exp cnt=0002 obs=%h", instr_count, obs, exp[0]);
    end
  endtask

  task automatic test_halt();
    IR = 32'hD8000000;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (obs !== V_IDLE || instr_count !== 16'h0001) begin
      errors++;
      $display("FAIL halt_entry got obs=%h cnt=%h exp obs=%h cnt=0001", obs, instr_count, V_IDLE);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (obs !== V_IDLE || instr_count !== 16'h0001) begin
        errors++;
        $display("FAIL halt_hold%0d got obs=%h cnt=%h exp obs=%h cnt=0001", i, obs, instr_count, V_IDLE);
      end
    end
    do_reset();
    vectors++;
    if (obs !== V_IDLE || instr_count !== 16'h0000) begin
      errors++;
      $display("FAIL halt_reset got obs=%h cnt=%h exp obs=%h cnt=0000", obs, instr_count, V_IDLE);
    end
    step();
    vectors++;
    if (obs !== vec(S_T0, 16'h0, 16'h0, 4'h0, 1'b1)) begin
      errors++;
      $display("FAIL halt_restart got %h exp %h", obs, vec(S_T0, 16'h0, 16'h0, 4'h0, 1'b1));
    end
  endtask

  task automatic test_illegal();
    IR = 32'hF8000000;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (obs !== vec(12'h000, 16'h0, 16'h0, 4'h0, 1'b1) || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_t3 got obs=%h ill=%b exp obs=%h ill=0", obs,
               illegal_op, vec(12'h000, 16'h0, 16'h0, 4'h0, 1'b1));
    end
    step();
    vectors++;
    if (illegal_op !== 1'b1 || obs !== V_IDLE || instr_count !== 16'h0000) begin
      errors++;
      $display("FAIL illegal_halt got ill=%b obs=%h cnt=%h exp ill=1 obs=%h cnt=0000",
               illegal_op, obs, instr_count, V_IDLE);
    end
    step();
    vectors++;
    if (illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky got %b exp 1", illegal_op);
    end
    do_reset();
    vectors++;
    if (illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear got %b exp 0", illegal_op);
    end
  endtask

  task automatic test_reset_mid();
    IR = 32'h18918000;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (obs !== vec(S_T4, 16'h0, 16'h0008, 4'h1, 1'b1)) begin
      errors++;
      $display("FAIL midrst_t4 got %h exp %h", obs, vec(S_T4, 16'h0, 16'h0008, 4'h1, 1'b1));
    end
    do_reset();
    vectors++;
    if (obs !== V_IDLE || instr_count !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_idle got obs=%h cnt=%h exp obs=%h cnt=0000", obs, instr_count, V_IDLE);
    end
    step();
    vectors++;
    if (obs !== vec(S_T0, 16'h0, 16'h0, 4'h0, 1'b1)) begin
      errors++;
      $display("FAIL midrst_t0 got %h exp %h", obs, vec(S_T0, 16'h0, 16'h0, 4'h0, 1'b1));
    end
  endtask

  task automatic test_stop_early();
    IR = 32'h18918000;
    do_reset();
    step(); step(); step();  // now in T2
    Stop = 1'b1;
    step();                  // T3
    Stop = 1'b0;
    vectors++;
    if (obs !== vec(S_T3, 16'h0, 16'h0004, 4'h0, 1'b1)) begin
      errors++;
      $display("FAIL stop_t3 got %h exp %h", obs, vec(S_T3, 16'h0, 16'h0004, 4'h0, 1'b1));
    end
    step(); step();          // T5
    vectors++;
    if (obs !== vec(S_T5, 16'h0002, 16'h0, 4'h0, 1'b1)) begin
      errors++;
      $display("FAIL stop_t5 got %h exp %h", obs, vec(S_T5, 16'h0002, 16'h0, 4'h0, 1'b1));
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (obs !== V_IDLE || instr_count !== 16'h0001) begin
        errors++;
        $display("FAIL stop_halt%0d got obs=%h cnt=%h exp obs=%h cnt=0001", i, obs, instr_count, V_IDLE);
      end
    end
  endtask

  task automatic test_stop_in_t5();
    IR = 32'h18918000;
    do_reset();
    for (int i = 0; i < 6; i++) step();  // T5
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    vectors++;
    if (obs !== V_IDLE || instr_count !== 16'h0001) begin
      errors++;
      $display("FAIL stop_t5_halt got obs=%h cnt=%h exp obs=%h cnt=0001", obs, instr_count, V_IDLE);
    end
  endtask

  task automatic test_back_to_back_stop();
    IR = 32'hD0000000;
    do_reset();
    for (int i = 0; i < 5; i++) step();  // T0 of second nop
    Stop = 1'b1;
    vectors++;
    if (obs !== vec(S_T0, 16'h0, 16'h0, 4'h0, 1'b1) || instr_count !== 16'h0001) begin
      errors++;
      $display("FAIL b2b_t0 got obs=%h cnt=%h exp obs=%h cnt=0001", obs, instr_count,
               vec(S_T0, 16'h0, 16'h0, 4'h0, 1'b1));
    end
    step();
    Stop = 1'b0;
    step(); step();          // T3 of second nop
    vectors++;
    if (obs !== vec(12'h000, 16'h0, 16'h0, 4'h0, 1'b1)) begin
      errors++;
      $display("FAIL b2b_t3 got %h exp %h", obs, vec(12'h000, 16'h0, 16'h0, 4'h0, 1'b1));
    end
    step();
    vectors++;
    if (obs !== V_IDLE || instr_count !== 16'h0002) begin
      errors++;
      $display("FAIL b2b_halt got obs=%h cnt=%h exp obs=%h cnt=0002", obs, instr_count, V_IDLE);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1;
    Stop  = 1'b0;
    IR    = 32'h0;
    test_reset();
    test_add();
    test_sub();
    test_logic_addi();
    test_nop();
    test_halt();
    test_illegal();
    test_reset_mid();
    test_stop_early();
    test_stop_in_t5();
    test_back_to_back_stop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
